pipeline_hazard_ctrl: RTL and testbench



---
 rtl/pipeline_ctrl_pkg.sv | 7 +
 rtl/mul_stall_timer.sv | 19 +
 rtl/pipeline_hazard_ctrl.sv | 89 ++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 117 +++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared state encoding and sizing constants for the hazard controller
package pipeline_ctrl_pkg;
  typedef enum logic [1:0] {INIT, RUN, MUL_BUSY} state_e;
  localparam int REG_AW      = 5;
  localparam int MUL_LAT_MAX = 16;
  localparam int CNT_W       = 4;
endpackage

// File: rtl/mul_stall_timer.sv
// mul_stall_timer: loadable down-counter with freeze and zero flag for multiply occupancy
import pipeline_ctrl_pkg::*;
module mul_stall_timer (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             freeze_i,
  output logic             zero_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // load wins; otherwise count down to zero unless frozen
  always_comb cnt_d = load_i ? load_val_i : (freeze_i || cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
  // counter register, cleared on reset so an aborted multiply leaves no residue
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: hold/clear control for the 5-stage pipeline; HAZARD_PERF_CNT_EN adds perf counters
import pipeline_ctrl_pkg::*;
module pipeline_hazard_ctrl #(
  parameter int REG_AW  = pipeline_ctrl_pkg::REG_AW,
  parameter int MUL_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_branch_taken,
  input  logic              ex_mul_start,
  input  logic              dmem_wait,
  output logic              pc_hold,
  output logic              if_id_hold,
  output logic              if_id_clear,
  output logic              id_ex_hold,
  output logic              id_ex_clear,
  output logic              ex_mem_hold,
  output logic              ex_mem_clear,
  output logic              mem_wb_hold,
  output logic              mem_wb_clear
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_events
`endif
);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MUL_LAT - 2);
  if (MUL_LAT < 2 || MUL_LAT > MUL_LAT_MAX) begin : g_bad_lat
    $error("MUL_LAT out of range");
  end
  state_e state_q;
  logic   cnt_zero, in_init, in_run, in_busy, load_use, mul_go;
  logic   frz, mst, br, lu;
  assign in_init  = state_q == INIT;
  assign in_run   = state_q == RUN;
  assign in_busy  = state_q == MUL_BUSY;
  assign load_use = ex_mem_read && ex_reg_write && ex_rd != '0 &&
                    ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
  assign mul_go   = in_run && !dmem_wait && ex_mul_start;
  assign frz      = (in_run || in_busy) && dmem_wait;
  assign mst      = mul_go || (in_busy && !dmem_wait && !cnt_zero);
  assign br       = in_run && !dmem_wait && !ex_mul_start && ex_branch_taken;
  assign lu       = in_run && !dmem_wait && !ex_mul_start && !ex_branch_taken && load_use;
  assign pc_hold      = in_init || frz || mst || lu;
  assign if_id_hold   = frz || mst || lu;
  assign if_id_clear  = in_init || br;
  assign id_ex_hold   = frz || mst;
  assign id_ex_clear  = in_init || br || lu;
  assign ex_mem_hold  = frz;
  assign ex_mem_clear = in_init || mst;
  assign mem_wb_hold  = 1'b0;
  assign mem_wb_clear = in_init || frz;
  mul_stall_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (mul_go),
    .load_val_i (LOAD_VAL),
    .freeze_i   (dmem_wait || !in_busy),
    .zero_o     (cnt_zero)
  );
  // control FSM: one INIT cycle, then RUN, with MUL_BUSY covering multiply occupancy
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= INIT;
    else
      case (state_q)
        INIT:     state_q <= RUN;
        RUN:      if (mul_go) state_q <= MUL_BUSY;
        MUL_BUSY: if (!dmem_wait && cnt_zero) state_q <= RUN;
        default:  state_q <= INIT;
      endcase
`ifdef HAZARD_PERF_CNT_EN
  // wrapping counters of stalled cycles and taken-branch flushes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (pc_hold && !in_init) stall_cycles <= stall_cycles + 32'd1;
      if (br) flush_events <= flush_events + 32'd1;
    end
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench driving directed hazard scenarios
module tb_pipeline_hazard_ctrl;
  localparam logic [8:0] Z   = 9'b000000000;
  localparam logic [8:0] INI = 9'b101010101;
  localparam logic [8:0] LU  = 9'b110010000;
  localparam logic [8:0] BR  = 9'b001010000;
  localparam logic [8:0] FZ  = 9'b110101001;
  localparam logic [8:0] MS  = 9'b110100100;
  logic clk = 0, rst_n = 0;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, ex_rd = 0;
  logic id_uses_rs1 = 0, id_uses_rs2 = 0, ex_reg_write = 0, ex_mem_read = 0;
  logic ex_branch_taken = 0, ex_mul_start = 0, dmem_wait = 0;
  logic pc_hold, if_id_hold, if_id_clear, id_ex_hold, id_ex_clear;
  logic ex_mem_hold, ex_mem_clear, mem_wb_hold, mem_wb_clear;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events;
`endif
  logic [8:0] exp_q[$];
  int step_q[$];
  int n_cmp = 0, n_err = 0, step = 0;
  always #5 clk = ~clk;
  pipeline_hazard_ctrl #(.REG_AW(5), .MUL_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .ex_mul_start(ex_mul_start), .dmem_wait(dmem_wait),
    .pc_hold(pc_hold), .if_id_hold(if_id_hold), .if_id_clear(if_id_clear),
    .id_ex_hold(id_ex_hold), .id_ex_clear(id_ex_clear), .ex_mem_hold(ex_mem_hold),
    .ex_mem_clear(ex_mem_clear), .mem_wb_hold(mem_wb_hold), .mem_wb_clear(mem_wb_clear)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
  );
  task automatic drive(input bit rn, dw, ms, bt, mr, rw, input logic [4:0] rd, rs1, rs2,
                       input bit u1, u2, input logic [8:0] e);
    @(posedge clk);
    #1;
    rst_n = rn; dmem_wait = dw; ex_mul_start = ms; ex_branch_taken = bt;
    ex_mem_read = mr; ex_reg_write = rw; ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_uses_rs1 = u1; id_uses_rs2 = u2;
    step++;
    exp_q.push_back(e);
    step_q.push_back(step);
  endtask
  task automatic idle(input logic [8:0] e);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e);
  endtask
  always @(negedge clk) begin
    logic [8:0] got, e;
    int s;
    if (exp_q.size() != 0) begin
      got = {pc_hold, if_id_hold, if_id_clear, id_ex_hold, id_ex_clear,
             ex_mem_hold, ex_mem_clear, mem_wb_hold, mem_wb_clear};
      e = exp_q.pop_front();
      s = step_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL step%0d outputs got=%b want=%b", s, got, e);
      end
    end
  end
  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, INI);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, INI);
    idle(INI);
    idle(Z);
    drive(1, 0, 0, 0, 1, 1, 5, 0, 5, 0, 1, LU);
    idle(Z);
    drive(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, Z);
    drive(1, 0, 0, 1, 1, 1, 5, 0, 5, 0, 1, BR);
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, MS);
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, MS);
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, MS);
    drive(1, 0, 1, 1, 1, 1, 5, 0, 5, 0, 1, Z);
    idle(Z);
`ifdef HAZARD_PERF_CNT_EN
    @(negedge clk);
    n_cmp += 2;
    if (stall_cycles !== 32'd4) begin
      n_err++;
      $display("FAIL stall_cycles got=%0d want=4", stall_cycles);
    end
    if (flush_events !== 32'd1) begin
      n_err++;
      $display("FAIL flush_events got=%0d want=1", flush_events);
    end
`endif
    drive(1, 0, 0, 0, 1, 1, 7, 7, 0, 1, 0, LU);
    drive(1, 0, 0, 0, 1, 1, 7, 7, 0, 0, 0, Z);
    drive(1, 0, 0, 0, 0, 1, 7, 7, 0, 1, 0, Z);
    drive(1, 0, 0, 0, 1, 0, 7, 7, 0, 1, 0, Z);
    drive(1, 1, 0, 1, 1, 1, 7, 7, 0, 1, 0, FZ);
    idle(Z);
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, MS);
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, MS);
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, FZ);
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, FZ);
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, MS);
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, Z);
    idle(Z);
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, MS);
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, MS);
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, INI);
    idle(INI);
    idle(Z);
    idle(Z);
    repeat (3) @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
